// File: rtl/L9_pkg.sv
`default_nettype none
// ============================================================================
// Module   : L9_pkg
// Purpose  : Shared lane limits, bias-select code and state encoding for the
//            layer-9 accumulator/bias stage.
// Revision : 1.0  initial release
// ============================================================================
package L9_pkg;

    localparam int LANE_W   = 18;
    localparam int LANE_MAX = 131071;
    localparam int LANE_MIN = -131072;

    // Bias-mux select code that makes the mux drive zero bias.
    localparam logic [2:0] Z_NO_BIAS = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_BIAS = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_add_lane_L9.sv
`default_nettype none
// ============================================================================
// Module   : sat_add_lane_L9
// Purpose  : One lane of accumulator + bias add, 18-bit signed saturation and
//            optional ReLU (macro BIAS_ACC_L9_RELU_EN).
// Revision : 1.0  initial release
// ============================================================================
module sat_add_lane_L9
    import L9_pkg::*;
#(
    parameter int ACC_W = 21
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [LANE_W-1:0] i_bias,
    output logic signed [LANE_W-1:0] o_result
);

    // One guard bit above the accumulator so the bias add itself cannot wrap.
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] c_sat_max = SUM_W'(LANE_MAX);
    localparam logic signed [SUM_W-1:0] c_sat_min = SUM_W'(LANE_MIN);

    logic signed [SUM_W-1:0]  w_sum;
    logic signed [LANE_W-1:0] w_sat;

    always_comb begin
        w_sum = {i_acc[ACC_W-1], i_acc}
              + {{(SUM_W-LANE_W){i_bias[LANE_W-1]}}, i_bias};
        if (w_sum > c_sat_max) begin
            w_sat = LANE_W'(LANE_MAX);
        end else if (w_sum < c_sat_min) begin
            w_sat = LANE_W'(LANE_MIN);
        end else begin
            w_sat = w_sum[LANE_W-1:0];
        end
`ifdef BIAS_ACC_L9_RELU_EN
        o_result = w_sat[LANE_W-1] ? '0 : w_sat;
`else
        o_result = w_sat;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/bias_acc_l9.sv
`default_nettype none
// ============================================================================
// Module   : bias_acc_l9
// Purpose  : Layer-9 accumulator: sums N_CHUNK partial-sum beats per group,
//            adds the bias bank selected on z, saturates, emits one beat per
//            group for N_GROUP groups. ReLU option: BIAS_ACC_L9_RELU_EN.
// Revision : 1.0  initial release
// ============================================================================
module bias_acc_l9
    import L9_pkg::*;
#(
    parameter int N_adder_tree = 16,
    parameter int N_CHUNK      = 4,
    parameter int N_GROUP      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_adder_tree*LANE_W-1:0] in_data,
    input  logic [N_adder_tree*LANE_W-1:0] BIAS,
    output logic [2:0]                     z,
    output logic                           out_valid,
    output logic [N_adder_tree*LANE_W-1:0] out_data,
    output logic                           busy,
    output logic                           done
);

    localparam int ACC_W = LANE_W + $clog2(N_CHUNK) + 1;
    localparam int CNT_W = $clog2(N_CHUNK + 1);
    localparam int BUS_W = N_adder_tree * LANE_W;

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc [N_adder_tree];
    logic [CNT_W-1:0]        r_chunk;
    logic [2:0]              r_group;
    logic [BUS_W-1:0]        w_sat;
    logic                    w_accept;
    logic                    w_last_beat;
    logic                    w_last_group;

    assign w_accept     = (r_state == ST_ACC) && in_valid;
    assign w_last_beat  = (r_chunk == CNT_W'(N_CHUNK - 1));
    assign w_last_group = (r_group == 3'(N_GROUP - 1));

    generate
        for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
            sat_add_lane_L9 #(
                .ACC_W (ACC_W)
            ) u_lane (
                .i_acc    (r_acc[i]),
                .i_bias   (BIAS[i*LANE_W +: LANE_W]),
                .o_result (w_sat[i*LANE_W +: LANE_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_chunk   <= '0;
            r_group   <= '0;
            in_ready  <= 1'b0;
            z         <= Z_NO_BIAS;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < N_adder_tree; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_ACC;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        z        <= 3'd0;
                        r_group  <= '0;
                        r_chunk  <= '0;
                        for (int i = 0; i < N_adder_tree; i++) begin
                            r_acc[i] <= '0;
                        end
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        for (int i = 0; i < N_adder_tree; i++) begin
                            r_acc[i] <= r_acc[i]
                                + {{(ACC_W-LANE_W){in_data[i*LANE_W+LANE_W-1]}},
                                   in_data[i*LANE_W +: LANE_W]};
                        end
                        r_chunk <= r_chunk + 1'b1;
                        if (w_last_beat) begin
                            r_state  <= ST_BIAS;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ST_BIAS: begin
                    // z has held this group's bank since the group began.
                    out_data  <= w_sat;
                    out_valid <= 1'b1;
                    r_chunk   <= '0;
                    r_group   <= r_group + 3'd1;
                    for (int i = 0; i < N_adder_tree; i++) begin
                        r_acc[i] <= '0;
                    end
                    if (w_last_group) begin
                        r_state <= ST_FIN;
                        z       <= Z_NO_BIAS;
                    end else begin
                        r_state  <= ST_ACC;
                        in_ready <= 1'b1;
                        z        <= r_group + 3'd1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bias_acc_l9.sv
`default_nettype none
// ============================================================================
// Module   : tb_bias_acc_l9
// Purpose  : Self-checking bench for bias_acc_l9 with a lane-arithmetic
//            reference model; honours BIAS_ACC_L9_RELU_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_bias_acc_l9;

    localparam int N      = 16;
    localparam int NC     = 4;
    localparam int NG     = 4;
    localparam int LW     = 18;
    localparam int BW     = N * LW;
    localparam int NB     = NC * NG;
    localparam int BUDGET = 200;
    localparam int MIN_T  = NG * (NC + 1) + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic [BW-1:0] BIAS;
    logic [2:0]    z;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          busy;
    logic          done;

    bias_acc_l9 #(.N_adder_tree(N), .N_CHUNK(NC), .N_GROUP(NG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .BIAS(BIAS), .z(z),
        .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Bias mux model: four banks, select code 3'b100 gives zero bias.
    logic [BW-1:0] bank  [4];
    logic [BW-1:0] beats [NB];
    assign BIAS = z[2] ? '0 : bank[z[1:0]];

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [2:0]    z_log    [BUDGET];
    logic          rdy_log  [BUDGET];
    logic          busy_log [BUDGET];
    int            ov_cyc   [8];
    logic [BW-1:0] ov_data  [8];
    int            n_ov;
    int            done_cyc;
    bit            timed_out;

    function automatic logic [BW-1:0] const_vec(input int val);
        logic [BW-1:0] v;
        for (int l = 0; l < N; l++) v[l*LW +: LW] = LW'(val);
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_vec();
        logic [BW-1:0] v;
        for (int l = 0; l < N; l++) begin
            case ($urandom_range(3))
                0:       v[l*LW +: LW] = 18'h1FFFF;
                1:       v[l*LW +: LW] = 18'h20000;
                default: v[l*LW +: LW] = LW'($urandom);
            endcase
        end
        return v;
    endfunction

    // Reference: plain integer sum of the group's beats plus its bias bank.
    function automatic int exp_lane(input int g, input int l);
        int s;
        s = int'($signed(bank[g][l*LW +: LW]));
        for (int c = 0; c < NC; c++) s += int'($signed(beats[g*NC+c][l*LW +: LW]));
        if (s > 131071) s = 131071;
        if (s < -131072) s = -131072;
`ifdef BIAS_ACC_L9_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    function automatic logic [BW-1:0] exp_vec(input int g);
        logic [BW-1:0] v;
        for (int l = 0; l < N; l++) v[l*LW +: LW] = LW'(exp_lane(g, l));
        return v;
    endfunction

    task automatic randomize_layer();
        for (int g = 0; g < 4; g++) bank[g] = rand_vec();
        for (int b = 0; b < NB; b++) beats[b] = rand_vec();
    endtask

    // Drives one layer and records what the DUT shows; cycle 1 is the cycle after start.
    task automatic run_layer(input bit hold, input bit noise);
        int beat;
        n_ov = 0; done_cyc = -1; beat = 0; timed_out = 1'b0;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; in_data = rand_vec();
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < BUDGET; cyc++) begin
            z_log[cyc] = z; rdy_log[cyc] = in_ready; busy_log[cyc] = busy;
            if (out_valid && n_ov < 8) begin
                ov_cyc[n_ov] = cyc; ov_data[n_ov] = out_data; n_ov++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = noise && ($urandom_range(3) == 0);
            if (beat >= NB) begin
                in_valid = 1'b1; in_data = rand_vec();
            end else if (hold || $urandom_range(2) != 0) begin
                in_valid = 1'b1;
                if (in_ready) begin
                    in_data = beats[beat]; beat++;
                end else begin
                    in_data = rand_vec();
                end
            end else begin
                in_valid = 1'b0; in_data = rand_vec();
            end
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0;
        if (done_cyc < 0) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp += 6;
        if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset.in_ready got %b want 0", in_ready); end
        if (z !== 3'b100)       begin n_fail++; $display("FAIL reset.z got %b want 100", z); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset.out_valid got %b want 0", out_valid); end
        if (out_data !== '0)    begin n_fail++; $display("FAIL reset.out_data got %h want 0", out_data); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset.busy got %b want 0", busy); end
        if (done !== 1'b0)      begin n_fail++; $display("FAIL reset.done got %b want 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int g = 0; g < 4; g++) bank[g] = const_vec(g == 0 ? 7 : g);
        for (int b = 0; b < NB; b++) beats[b] = const_vec(100);
        run_layer(1'b1, 1'b0);
        n_cmp++;
        if (timed_out || n_ov != NG) begin
            n_fail++; $display("FAIL basic.pulses got %0d (timeout %b) want %0d", n_ov, timed_out, NG);
        end
        n_cmp++;
        if (ov_data[0] !== const_vec(407)) begin
            n_fail++; $display("FAIL basic.group0 got %h want lanes of 407", ov_data[0]);
        end
        for (int g = 1; g < NG; g++) begin
            n_cmp++;
            if (ov_data[g] !== const_vec(400 + g)) begin
                n_fail++; $display("FAIL basic.group%0d got %h want lanes of %0d", g, ov_data[g], 400 + g);
            end
        end
        n_cmp++;
        if (ov_cyc[0] != NC + 2) begin
            n_fail++; $display("FAIL basic.latency got cycle %0d want %0d", ov_cyc[0], NC + 2);
        end
        for (int c = 1; c <= NC + 1; c++) begin
            n_cmp++;
            if (z_log[c] !== 3'd0) begin
                n_fail++; $display("FAIL basic.z cycle %0d got %b want 000", c, z_log[c]);
            end
        end
        n_cmp++;
        if (done_cyc != MIN_T) begin
            n_fail++; $display("FAIL basic.done_time got %0d want %0d", done_cyc, MIN_T);
        end
    endtask

    task automatic test_saturation();
        randomize_layer();
        bank[0] = const_vec(5);
        bank[1] = const_vec(-1);
        for (int c = 0; c < NC; c++) begin
            beats[c]      = const_vec(131071);
            beats[NC + c] = const_vec(-131072);
        end
        run_layer(1'b1, 1'b0);
        n_cmp++;
        if (ov_data[0] !== const_vec(131071)) begin
            n_fail++; $display("FAIL sat.pos got %h want lanes of 131071", ov_data[0]);
        end
        n_cmp++;
`ifdef BIAS_ACC_L9_RELU_EN
        if (ov_data[1] !== const_vec(0)) begin
            n_fail++; $display("FAIL sat.neg got %h want lanes of 0", ov_data[1]);
        end
`else
        if (ov_data[1] !== const_vec(-131072)) begin
            n_fail++; $display("FAIL sat.neg got %h want lanes of -131072", ov_data[1]);
        end
`endif
        for (int g = 2; g < NG; g++) begin
            n_cmp++;
            if (ov_data[g] !== exp_vec(g)) begin
                n_fail++; $display("FAIL sat.group%0d got %h want %h", g, ov_data[g], exp_vec(g));
            end
        end
    endtask

    task automatic test_sequencing();
        int completed;
        logic [2:0] zexp;
        randomize_layer();
        run_layer(1'b0, 1'b0);
        n_cmp++;
        if (timed_out || n_ov != NG) begin
            n_fail++; $display("FAIL seq.pulses got %0d (timeout %b) want %0d", n_ov, timed_out, NG);
        end else begin
            for (int c = 1; c <= done_cyc; c++) begin
                completed = 0;
                for (int g = 0; g < NG; g++) if (ov_cyc[g] <= c) completed++;
                zexp = (completed < NG) ? 3'(completed) : 3'b100;
                n_cmp++;
                if (z_log[c] !== zexp) begin
                    n_fail++; $display("FAIL seq.z cycle %0d got %b want %b", c, z_log[c], zexp);
                end
                n_cmp++;
                if (busy_log[c] !== (c != done_cyc)) begin
                    n_fail++; $display("FAIL seq.busy cycle %0d got %b want %b", c, busy_log[c], c != done_cyc);
                end
            end
            n_cmp++;
            if (done_cyc != ov_cyc[NG-1] + 1) begin
                n_fail++; $display("FAIL seq.done got cycle %0d want %0d", done_cyc, ov_cyc[NG-1] + 1);
            end
            for (int g = 0; g < NG; g++) begin
                n_cmp++;
                if (ov_data[g] !== exp_vec(g)) begin
                    n_fail++; $display("FAIL seq.group%0d got %h want %h", g, ov_data[g], exp_vec(g));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit rexp;
        randomize_layer();
        run_layer(1'b1, 1'b0);
        n_cmp++;
        if (timed_out || n_ov != NG || done_cyc != MIN_T) begin
            n_fail++; $display("FAIL b2b.timing got %0d pulses done %0d want %0d pulses done %0d", n_ov, done_cyc, NG, MIN_T);
        end else begin
            for (int c = 1; c <= done_cyc; c++) begin
                rexp = (c < ov_cyc[NG-1] - 1);
                for (int g = 0; g < NG; g++) if (c == ov_cyc[g] - 1) rexp = 1'b0;
                n_cmp++;
                if (rdy_log[c] !== rexp) begin
                    n_fail++; $display("FAIL b2b.in_ready cycle %0d got %b want %b", c, rdy_log[c], rexp);
                end
            end
            for (int g = 0; g < NG; g++) begin
                n_cmp++;
                if (ov_data[g] !== exp_vec(g)) begin
                    n_fail++; $display("FAIL b2b.group%0d got %h want %h", g, ov_data[g], exp_vec(g));
                end
            end
        end
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = rand_vec();
            n_cmp++;
            if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || z !== 3'b100) begin
                n_fail++;
                $display("FAIL illegal.idle got rdy %b busy %b ov %b z %b want 0 0 0 100", in_ready, busy, out_valid, z);
            end
        end
        in_valid = 1'b0;
        randomize_layer();
        run_layer(1'b0, 1'b1);
        n_cmp++;
        if (timed_out || n_ov != NG) begin
            n_fail++; $display("FAIL illegal.pulses got %0d (timeout %b) want %0d", n_ov, timed_out, NG);
        end
        for (int g = 0; g < NG; g++) begin
            n_cmp++;
            if (ov_data[g] !== exp_vec(g)) begin
                n_fail++; $display("FAIL illegal.group%0d got %h want %h", g, ov_data[g], exp_vec(g));
            end
        end
    endtask

    task automatic test_reset_mid();
        int beat;
        randomize_layer();
        beat = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < BUDGET && beat < NC + 2; cyc++) begin
            in_valid = 1'b1;
            if (in_ready) begin
                in_data = beats[beat]; beat++;
            end else begin
                in_data = rand_vec();
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || z !== 3'b100 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid.outputs got rdy %b z %b ov %b busy %b done %b data %h want reset values",
                     in_ready, z, out_valid, busy, done, out_data);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid.hold got ov %b done %b want 0 0", out_valid, done);
        end
        rst_n = 1'b1;
        randomize_layer();
        run_layer(1'b1, 1'b0);
        n_cmp++;
        if (timed_out || n_ov != NG) begin
            n_fail++; $display("FAIL rstmid.pulses got %0d (timeout %b) want %0d", n_ov, timed_out, NG);
        end
        for (int g = 0; g < NG; g++) begin
            n_cmp++;
            if (ov_data[g] !== exp_vec(g)) begin
                n_fail++; $display("FAIL rstmid.group%0d got %h want %h", g, ov_data[g], exp_vec(g));
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 4; g++) bank[g] = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_sequencing();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
